// File: rtl/bank_row_cache_if.sv
// Bank-side request/response bundle for bank_row_cache.
// master: bank FSM + data-move engine; slave: the row cache.
interface bank_row_cache_if #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17
);
    logic [4:0]           BankFSM;
    logic [ADDRWIDTH-1:0] RowId;
    logic                 sync;
    logic [CHWIDTH-1:0]   cRowId;
    logic                 hit;
    logic                 stall;
    logic                 evict_valid;
    logic [ADDRWIDTH-1:0] evict_RowId;
    logic [CHWIDTH:0]     occupancy;

    modport master (
        output BankFSM, RowId, sync,
        input  cRowId, hit, stall, evict_valid, evict_RowId, occupancy
    );

    modport slave (
        input  BankFSM, RowId, sync,
        output cRowId, hit, stall, evict_valid, evict_RowId, occupancy
    );
endinterface

// File: rtl/bank_row_cache.sv
// Per-bank row cache: fully associative RowId -> cache slot map,
// allocate on miss, stall until sync, optional dirty write-back.
// Ports: clk, reset (async, active-high), bus (bank_row_cache_if.slave):
//   in  BankFSM, RowId, sync
//   out cRowId, hit, stall, evict_valid, evict_RowId, occupancy
// Option: define MEMSYNC_WRITEBACK_EN to build dirty tracking + EVICT.
module bank_row_cache #(
    parameter int         CHWIDTH    = 6,
    parameter int         ADDRWIDTH  = 17,
    parameter logic [4:0] READ_CODE  = 5'b01011,
    parameter logic [4:0] WRITE_CODE = 5'b10010
) (
    input logic              clk,
    input logic              reset,
    bank_row_cache_if.slave  bus
);
    localparam int CHROWS = 1 << CHWIDTH;
    localparam logic [CHWIDTH:0] FULL = (CHWIDTH+1)'(CHROWS);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, EVICT, ALLOCATE, ACCESS
    } state_t;

    state_t state, state_n;

    logic                 req, req_q, req_edge, is_wr;
    logic [ADDRWIDTH-1:0] row_q;
    logic                 wr_q;
    logic [ADDRWIDTH-1:0] tags [CHROWS];
    logic [CHROWS-1:0]    valid;
    logic [CHWIDTH-1:0]   crow_q, rr_q, hit_idx, free_idx, victim;
    logic                 hit_q, lk_hit, any_free, victim_dirty;
    logic [CHWIDTH:0]     occ_q;
    logic                 stall_c, ev_valid_c;
    logic [ADDRWIDTH-1:0] ev_row_c;

    assign is_wr    = (bus.BankFSM == WRITE_CODE);
    assign req      = (bus.BankFSM == READ_CODE) || is_wr;
    assign req_edge = req && !req_q;

    // Parallel tag match and free-slot search; descending scan
    // leaves the lowest matching index in each result.
    always_comb begin
        lk_hit   = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == row_q) begin
                lk_hit  = 1'b1;
                hit_idx = CHWIDTH'(i);
            end
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = CHWIDTH'(i);
            end
        end
    end

    assign victim = any_free ? free_idx : rr_q;

`ifdef MEMSYNC_WRITEBACK_EN
    logic [CHROWS-1:0] dirty;

    assign victim_dirty = valid[victim] && dirty[victim];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= '0;
        end else begin
            unique case (state)
                EVICT:    if (bus.sync) dirty[crow_q] <= 1'b0;
                ALLOCATE: if (bus.sync) dirty[crow_q] <= wr_q;
                ACCESS:   if (wr_q) dirty[crow_q] <= 1'b1;
                default:  ;
            endcase
        end
    end
`else
    assign victim_dirty = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: once past IDLE a transaction always runs to ACCESS
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (req_edge) state_n = LOOKUP;
            LOOKUP: begin
                if (lk_hit)            state_n = ACCESS;
                else if (victim_dirty) state_n = EVICT;
                else                   state_n = ALLOCATE;
            end
            EVICT:    if (bus.sync) state_n = ALLOCATE;
            ALLOCATE: if (bus.sync) state_n = ACCESS;
            ACCESS:   if (bus.BankFSM == 5'd0) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        stall_c    = (state == LOOKUP) || (state == EVICT) ||
                     (state == ALLOCATE);
        ev_valid_c = 1'b0;
        ev_row_c   = '0;
`ifdef MEMSYNC_WRITEBACK_EN
        if (state == EVICT) begin
            ev_valid_c = 1'b1;
            ev_row_c   = tags[crow_q];
        end
`endif
    end

    // Tag storage needs no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (state == ALLOCATE && bus.sync) tags[crow_q] <= row_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            row_q  <= '0;
            wr_q   <= 1'b0;
            valid  <= '0;
            rr_q   <= '0;
            crow_q <= '0;
            hit_q  <= 1'b0;
            occ_q  <= '0;
        end else begin
            req_q <= req;
            unique case (state)
                IDLE: begin
                    if (req_edge) begin
                        row_q <= bus.RowId;
                        wr_q  <= is_wr;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        crow_q <= hit_idx;
                        hit_q  <= 1'b1;
                    end else begin
                        crow_q <= victim;
                        hit_q  <= 1'b0;
                        if (!any_free) rr_q <= rr_q + CHWIDTH'(1);
                    end
                end
                EVICT: begin
                    // Victim leaves the array; ALLOCATE re-counts it
                    if (bus.sync) begin
                        valid[crow_q] <= 1'b0;
                        occ_q         <= occ_q - (CHWIDTH+1)'(1);
                    end
                end
                ALLOCATE: begin
                    if (bus.sync) begin
                        valid[crow_q] <= 1'b1;
                        if (!valid[crow_q] && occ_q != FULL)
                            occ_q <= occ_q + (CHWIDTH+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cRowId      = crow_q;
    assign bus.hit         = hit_q;
    assign bus.stall       = stall_c;
    assign bus.evict_valid = ev_valid_c;
    assign bus.evict_RowId = ev_row_c;
    assign bus.occupancy   = occ_q;
endmodule

// File: doc/bank_row_cache.md
# bank_row_cache

- Per-bank row-cache controller, parametrised successor to the single-bank row sync logic.
- Maps a DRAM row address (RowId) to one of CHROWS cache-row slots through a fully associative tag array.
- Allocates a slot on a miss, stalls the bank until the data-move engine pulses sync, and optionally tracks dirty rows and hands them back for write-back before reuse.
- One instance sits beside each bank FSM in the memory-sync top level.

## Interface

Parameters:
- CHWIDTH, 6: log2 of the number of cache-row slots (CHROWS = 2**CHWIDTH).
- ADDRWIDTH, 17: DRAM row address width.
- READ_CODE, 5'b01011: BankFSM encoding for a read.
- WRITE_CODE, 5'b10010: BankFSM encoding for a write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- BankFSM  in  5  current bank FSM state code; 0 means idle.
- RowId  in  ADDRWIDTH  DRAM row for the current request; sampled on the request edge.
- sync  in  1  single-cycle completion pulse from the data-move engine.
- cRowId  out  CHWIDTH  cache slot assigned to the current request.
- hit  out  1  the current request hit an existing valid slot.
- stall  out  1  the bank must hold; no access is permitted.
- evict_valid  out  1  a dirty victim is awaiting write-back.
- evict_RowId  out  ADDRWIDTH  DRAM row of the dirty victim.
- occupancy  out  CHWIDTH+1  number of valid slots.

## Operation

- Request definition: req = (BankFSM == READ_CODE) || (BankFSM == WRITE_CODE).
- Request edge: req is 1 this cycle and was 0 on the previous sample. Any other nonzero BankFSM code counts as req = 0.
- FSM states: IDLE, LOOKUP, EVICT, ALLOCATE, ACCESS.
- IDLE:
  - On a request edge, latch RowId and the write flag (BankFSM == WRITE_CODE).
  - Go to LOOKUP.
- LOOKUP:
  - Compare the latched row against all valid tags in parallel.
  - On a hit, set cRowId to the matching slot, set hit = 1, and go to ACCESS.
  - On a miss, select a victim:
    - The lowest-index invalid slot if one exists.
    - Otherwise the slot at the round-robin pointer; the pointer then increments mod CHROWS.
  - Set cRowId to the victim slot and hit = 0.
  - If the victim is valid and dirty (write-back builds only), go to EVICT; otherwise go to ALLOCATE.
- EVICT:
  - evict_valid = 1 and evict_RowId = victim tag.
  - On sync, clear the victim's valid bit and go to ALLOCATE.
- ALLOCATE:
  - Wait for sync.
  - On sync, write the tag, set valid = 1, set dirty = write flag, and go to ACCESS.
- ACCESS:
  - A write sets the slot's dirty bit.
  - Leave for IDLE on the first cycle BankFSM == 0.
- Once started, a transaction always completes. BankFSM returning to 0 during LOOKUP, EVICT or ALLOCATE does not abort it.
- sync in IDLE, LOOKUP or ACCESS is ignored. At most one sync is consumed per state.
- occupancy:
  - +1 on an ALLOCATE into a previously invalid slot.
  - Unchanged on replacement of a valid slot.
  - Saturates at CHROWS.
- Duplicate tags never exist, because a hit always takes priority over allocation.

## Timing

- Reset values: state IDLE; all valid and dirty bits 0; round-robin pointer 0; cRowId 0; hit 0; stall 0; evict_valid 0; evict_RowId 0; occupancy 0.
- Let edge E be the clock edge at which the request is first sampled.
  - LOOKUP runs during cycle E+1.
  - On a hit, ACCESS begins with hit = 1 and cRowId valid from E+2.
- stall is a Moore output: 1 in LOOKUP, EVICT and ALLOCATE; 0 in IDLE and ACCESS.
  - Minimum hit stall: 1 cycle.
  - Minimum clean-miss stall: 2 cycles (LOOKUP + ALLOCATE), with sync arriving on the first ALLOCATE cycle.
- A sync sampled in ALLOCATE makes ACCESS start the next cycle. A sync sampled in EVICT makes ALLOCATE start the next cycle.
- A new request edge is accepted only in IDLE. It needs at least one idle sample of BankFSM after ACCESS.
- A reset assertion mid-transaction takes effect immediately and clears all slot state.

## Configuration

- Macro: MEMSYNC_WRITEBACK_EN.
- Defined:
  - Dirty bits are maintained.
  - Dirty victims pass through EVICT and require one sync before ALLOCATE.
- Undefined:
  - No dirty storage is built.
  - EVICT is never entered.
  - evict_valid is tied 0 and evict_RowId is tied 0.
  - Every miss goes LOOKUP -> ALLOCATE.

## Test plan

- Cold miss: reset, then BankFSM = WRITE_CODE with RowId = 17'h00A5, sync on the 3rd cycle after E. Required: stall = 1 for E+1..E+3, cRowId = 0, hit = 0, occupancy = 1.
- Hit: after the cold miss, idle 1 cycle, then READ_CODE with RowId = 17'h00A5. Required: hit = 1 and cRowId = 0 at E+2, stall high for exactly 1 cycle, occupancy unchanged.
- Fill and wrap: 64 distinct rows, then a 65th row. Required: slots 0..63 assigned in order, occupancy = 64, 65th row gets slot 0 (pointer 0), and the next miss gets slot 1.
- Dirty eviction (macro defined): fill all slots with writes, then miss. Required: evict_valid = 1 with evict_RowId equal to slot 0's row, held until the first sync, then ALLOCATE waits for a second sync. Macro undefined: evict_valid stays 0 and one sync completes the miss.
- Abort and ignore: BankFSM returns to 0 during ALLOCATE and a sync arrives in IDLE. Required: the allocation still completes on the next in-state sync, the stray sync causes no change, and the non-request code 5'b00001 produces no request.
- Reset mid-ALLOCATE: assert reset. Required: all outputs return to their reset values immediately, occupancy = 0, and a following request to the previously cached row misses.
